owm_bus_master: RTL
===================

// Module: owm_bus_master
// PURPOSE
//  1-Wire bus master (initiator) link layer, the opposite end of our ows_* slave chain.
//  - Generates reset/presence sequences and byte-wide write/read time slots, LSB first.
//  - Drives the line open-drain through data_out/data_out_oe; samples data_in.
//  - Used as an on-FPGA master to exercise ows_top, and by host-side bridge logic.
// PARAMETERS
//  CLKS_PER_US  50   clk cycles per microsecond; prescaler terminal count, minimum 2
//  T_RST_US     480  reset low time, and presence-phase window length
//  T_PDS_US     70   presence sample point, measured from reset release
//  T_SLOT_US    70   total write/read slot length, recovery included
//  T_LOW1_US    6    low time for write-1 and for read slots
//  T_LOW0_US    60   low time for write-0
//  T_RDS_US     15   read sample point, measured from slot start
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  synchronous reset, active low
//  cmd_valid    in   1  command request
//  cmd_ready    out  1  high only in IDLE
//  cmd_op       in   2  00=RESET  01=WRITE_BYTE  10=READ_BYTE  11=NOP
//  cmd_data     in   8  byte for WRITE_BYTE
//  done         out  1  one-cycle pulse when a command completes
//  rd_data      out  8  byte from READ_BYTE; valid with done, held until the next READ_BYTE completes
//  presence     out  1  presence result of the last RESET; held
//  busy         out  1  ~cmd_ready
//  crc          out  8  running CRC-8 (see CONFIGURATION)
//  data_in      in   1  raw bus level, asynchronous
//  data_out     out  1  constant 0
//  data_out_oe  out  1  1 = pull bus low
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge) and its outputs:
//  - Reset values: data_out_oe=0, cmd_ready=1, busy=0, done=0, rd_data=0, presence=0, crc=0.
//  - State goes to IDLE.
//  - Reset mid-slot releases the bus on the next edge; the partial command is lost and no done pulse is issued.
//  Synchronizer, timebase and accept:
//  - data_in passes through a 2-flop synchronizer, so each sample is 2 clk late.
//  - The prescaler wraps at CLKS_PER_US-1 and produces us_tick. It restarts at 0 on every state entry.
//  - us_cnt is 9 bits and counts us_tick since state entry.
//  - Accept = cmd_valid & cmd_ready. cmd_op and cmd_data are latched; a shift register is loaded; bit_cnt is cleared.
//  FSM:
//  - IDLE: on accept go to RST_LOW (op 00), SLOT_LOW (01/10), or DONE (11).
//  - RST_LOW: oe=1 for T_RST_US, then RST_REL.
//  - RST_REL: oe=0. When us_cnt==T_PDS_US, presence <= ~sync_in. After T_RST_US go to DONE.
//  - SLOT_LOW: oe=1 for T_LOW0_US when writing a 0, otherwise T_LOW1_US; then SLOT_REL.
//  - SLOT_REL: oe=0.
//    - Read sample: when the total slot time == T_RDS_US, the bit is shifted in at MSB and the register shifts right.
//    - When the total slot time == T_SLOT_US, bit_cnt increments. At bit_cnt==7 go to DONE, else SLOT_LOW.
//    - Slot time counts through both SLOT_LOW and SLOT_REL, using a separate slot_us counter.
//  - DONE: done=1 for one cycle; rd_data is updated if the op was READ; then IDLE.
//  Bus and handshake rules:
//  - A bus held low by a slave does not stall timing. The master never checks the line during write slots.
//  - cmd_valid while busy is ignored. Commands are not queued.
//  - A back-to-back accept is possible in the cycle after done.
//  - Command latency, accept to done:
//    - RESET: 2*T_RST_US*CLKS_PER_US + 2 clk.
//    - byte: 8*T_SLOT_US*CLKS_PER_US + 2 clk.
// CONFIGURATION
//  OWM_CRC8_EN defined:
//  - crc is updated once per transferred bit (written or read) with polynomial x^8+x^5+x^4+1 (Dallas/Maxim), LSB first:
//    fb = crc[0]^bit; crc = {fb, crc[7:1]} ^ (fb ? 8'h0C : 0).
//  - A RESET command clears crc to 0 at accept.
//  OWM_CRC8_EN undefined:
//  - crc is tied to 8'h00 and no CRC logic is built.
// TESTING
//  - Bus model for all tests: CLKS_PER_US=4; the model pulls the bus low 15-75us after reset release.
//  - Test 1: RESET -> oe high 1920 clk; presence=1; done after 3842 clk.
//  - Test 2: RESET with no slave -> presence=0; done still pulses once.
//  - Test 3: WRITE_BYTE 8'hA5 -> low widths in order 6,60,6,60,60,6,60,6 us; each slot 280 clk.
//  - Test 4: READ_BYTE, model drives 8'h3C during sample windows -> rd_data=8'h3C at done.
//  - Test 5: rst_n=0 during slot 3 of WRITE -> oe=0 next clk; cmd_ready=1; no done pulse.
//  - Test 6 (OWM_CRC8_EN): RESET, write 28 FF 4A 01 0B 00 00, then read 1 byte -> crc==00 when the family-code/serial/CRC byte sequence 28 FF 4A 01 0B 00 00 + its CRC is fed; without the macro crc stays 00.

Source files
------------

// File: rtl/owm_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : owm_bus_master
// Desc     : 1-Wire bus master link layer: reset/presence sequences and
//            byte-wide write/read time slots (LSB first), open-drain drive.
//            Define OWM_CRC8_EN to build the running Dallas/Maxim CRC-8.
// Revision : 1.0 - initial release
// ============================================================================
module owm_bus_master #(
    parameter int unsigned CLKS_PER_US = 50,
    parameter int unsigned T_RST_US    = 480,
    parameter int unsigned T_PDS_US    = 70,
    parameter int unsigned T_SLOT_US   = 70,
    parameter int unsigned T_LOW1_US   = 6,
    parameter int unsigned T_LOW0_US   = 60,
    parameter int unsigned T_RDS_US    = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       presence,
    output logic       busy,
    output logic [7:0] crc,
    input  logic       data_in,
    output logic       data_out,
    output logic       data_out_oe
);

    localparam int unsigned c_pre_w = $clog2(CLKS_PER_US);
    localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(CLKS_PER_US - 1);

    localparam logic [8:0] c_rst_us  = 9'(T_RST_US);
    localparam logic [8:0] c_pds_us  = 9'(T_PDS_US);
    localparam logic [8:0] c_slot_us = 9'(T_SLOT_US);
    localparam logic [8:0] c_low1_us = 9'(T_LOW1_US);
    localparam logic [8:0] c_low0_us = 9'(T_LOW0_US);
    localparam logic [8:0] c_rds_us  = 9'(T_RDS_US);

    localparam logic [1:0] c_op_reset = 2'b00;
    localparam logic [1:0] c_op_write = 2'b01;
    localparam logic [1:0] c_op_read  = 2'b10;
    localparam logic [1:0] c_op_nop   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST_LOW  = 3'd1,
        S_RST_REL  = 3'd2,
        S_SLOT_LOW = 3'd3,
        S_SLOT_REL = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [c_pre_w-1:0]   r_pre;
    logic [8:0]           r_us;
    logic [8:0]           r_slot_us;
    logic [1:0]           r_op;
    logic [7:0]           r_shift;
    logic [2:0]           r_bit_cnt;
    logic                 r_oe;
    logic                 r_done;
    logic [7:0]           r_rd_data;
    logic                 r_presence;

    logic                 w_accept;
    logic                 w_us_tick;
    logic                 w_sync_in;
    logic                 w_in_slot;
    logic                 w_rd_sample;
    logic                 w_slot_end;
    logic [8:0]           w_low_us;

    assign w_accept    = cmd_valid && (r_state == S_IDLE);
    assign w_us_tick   = (r_pre == c_pre_max);
    assign w_sync_in   = r_sync[1];
    assign w_in_slot   = (r_state == S_SLOT_LOW) || (r_state == S_SLOT_REL);
    // Read bits are sampled once, on the first clock of the sample microsecond.
    assign w_rd_sample = w_in_slot && (r_op == c_op_read) &&
                         (r_slot_us == c_rds_us) && (r_pre == '0);
    assign w_slot_end  = (r_state == S_SLOT_REL) && w_us_tick &&
                         (r_slot_us == c_slot_us - 9'd1);
    assign w_low_us    = ((r_op == c_op_write) && !r_shift[0]) ? c_low0_us : c_low1_us;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sync     <= 2'b11;
            r_pre      <= '0;
            r_us       <= '0;
            r_slot_us  <= '0;
            r_op       <= c_op_nop;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_oe       <= 1'b0;
            r_done     <= 1'b0;
            r_rd_data  <= '0;
            r_presence <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], data_in};
            r_done <= 1'b0;

            if (w_us_tick) begin
                r_pre     <= '0;
                r_us      <= r_us + 9'd1;
                r_slot_us <= r_slot_us + 9'd1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end

            if (w_rd_sample) begin
                r_shift <= {w_sync_in, r_shift[7:1]};
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= cmd_op;
                        r_shift   <= cmd_data;
                        r_bit_cnt <= '0;
                        r_pre     <= '0;
                        r_us      <= '0;
                        r_slot_us <= '0;
                        case (cmd_op)
                            c_op_reset: begin
                                r_state <= S_RST_LOW;
                                r_oe    <= 1'b1;
                            end
                            c_op_write, c_op_read: begin
                                r_state <= S_SLOT_LOW;
                                r_oe    <= 1'b1;
                            end
                            default: r_state <= S_DONE;
                        endcase
                    end
                end

                S_RST_LOW: begin
                    if (w_us_tick && (r_us == c_rst_us - 9'd1)) begin
                        r_state <= S_RST_REL;
                        r_oe    <= 1'b0;
                        r_pre   <= '0;
                        r_us    <= '0;
                    end
                end

                S_RST_REL: begin
                    if ((r_us == c_pds_us) && (r_pre == '0)) begin
                        r_presence <= ~w_sync_in;
                    end
                    if (w_us_tick && (r_us == c_rst_us - 9'd1)) begin
                        r_state <= S_DONE;
                        r_pre   <= '0;
                        r_us    <= '0;
                    end
                end

                S_SLOT_LOW: begin
                    if (w_us_tick && (r_us == w_low_us - 9'd1)) begin
                        r_state <= S_SLOT_REL;
                        r_oe    <= 1'b0;
                        r_pre   <= '0;
                        r_us    <= '0;
                    end
                end

                S_SLOT_REL: begin
                    if (w_slot_end) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_pre     <= '0;
                        r_us      <= '0;
                        r_slot_us <= '0;
                        // Write data leaves LSB first; read data was shifted at sample time.
                        if (r_op == c_op_write) begin
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SLOT_LOW;
                            r_oe    <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    r_pre   <= '0;
                    r_us    <= '0;
                    if (r_op == c_op_read) begin
                        r_rd_data <= r_shift;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_oe    <= 1'b0;
                end
            endcase
        end
    end

`ifdef OWM_CRC8_EN
    logic [7:0] r_crc;
    logic       w_crc_en;
    logic       w_crc_bit;
    logic       w_crc_fb;

    assign w_crc_en  = w_rd_sample || (w_slot_end && (r_op == c_op_write));
    assign w_crc_bit = (r_op == c_op_read) ? w_sync_in : r_shift[0];
    assign w_crc_fb  = r_crc[0] ^ w_crc_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_crc <= '0;
        end else if (w_accept && (cmd_op == c_op_reset)) begin
            r_crc <= '0;
        end else if (w_crc_en) begin
            r_crc <= {w_crc_fb, r_crc[7:1]} ^ (w_crc_fb ? 8'h0C : 8'h00);
        end
    end

    assign crc = r_crc;
`else
    assign crc = 8'h00;
`endif

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = ~cmd_ready;
    assign done        = r_done;
    assign rd_data     = r_rd_data;
    assign presence    = r_presence;
    assign data_out    = 1'b0;
    assign data_out_oe = r_oe;

endmodule
`default_nettype wire
